sfifo_push_arbiter: RTL
=======================

Name: sfifo_push_arbiter

Overview:
- Shares the single write port of one SFIFO_18K_BLK between two producer streams, using round-robin arbitration with valid/ready handshakes.
- Sequences FIFO flushes: drives Async_Flush for a programmable number of cycles, blocks pushes while flushing, then reports completion.
- Keeps a saturating count of FIFO overrun cycles for status readout.
- Sits between producer logic and the FIFO wrapper; CLK connects to the same net as the FIFO CLK.

Parameters:
- DATA_WIDTH, 18, width of each requester's data and of FIFO_DIN. Legal values: 8, 9, 16, 18.
- FLUSH_CYCLES, 4, number of consecutive cycles FIFO_Async_Flush is held high. Must be ≥1.
- CNT_WIDTH, 8, width of OVERRUN_CNT.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ0_DIN  in  DATA_WIDTH  requester 0 data.
- REQ0_VALID  in  1  requester 0 has data.
- REQ0_READY  out  1  requester 0 data is accepted this cycle.
- REQ1_DIN  in  DATA_WIDTH  requester 1 data.
- REQ1_VALID  in  1  requester 1 has data.
- REQ1_READY  out  1  requester 1 data is accepted this cycle.
- FIFO_DIN  out  DATA_WIDTH  to FIFO DIN.
- FIFO_PUSH  out  1  to FIFO PUSH.
- FIFO_Async_Flush  out  1  to FIFO Async_Flush.
- FIFO_Full  in  1  from FIFO Full.
- FIFO_Overrun_Error  in  1  from FIFO Overrun_Error.
- FLUSH_REQ  in  1  request a flush sequence.
- FLUSH_BUSY  out  1  flush sequence in progress.
- FLUSH_DONE  out  1  one-cycle pulse when the flush completes.
- GRANT_ID  out  1  requester that has priority in the next contention.
- OVERRUN_CNT  out  CNT_WIDTH  saturating count of overrun cycles.

Behaviour:
- Reset values (RESET sampled high at a CLK edge):
  - State=IDLE, priority pointer PRI=0 (so GRANT_ID=0), flush counter=0, OVERRUN_CNT=0.
  - FLUSH_DONE=0, FIFO_Async_Flush=0, FLUSH_BUSY=0.
  - FIFO_PUSH=0 and both READY outputs=0 while RESET is high, regardless of the VALID inputs.
  - RESET applied mid-flush aborts the flush: Async_Flush drops on the next cycle and no FLUSH_DONE pulse is produced.
- Handshake and push path (combinational, zero latency):
  - push_ok = (state==IDLE) & !FLUSH_REQ & !FIFO_Full & !RESET.
  - Grant selection:
    - Only one requester VALID: that requester is granted.
    - Both VALID: requester PRI is granted.
  - REQk_READY = push_ok & grant==k. READY does not depend on that requester's own VALID beyond the grant selection.
  - FIFO_PUSH = OR of (REQk_VALID & REQk_READY).
  - FIFO_DIN = data of the granted requester. When FIFO_PUSH=0, FIFO_DIN is REQ0_DIN.
  - A transfer occurs when VALID & READY are both high at a CLK edge.
- Arbitration update: after a transfer by requester k, PRI <= ~k. With no transfer, PRI holds. A lone requester therefore never starves, and under constant contention the grants alternate 0,1,0,1.
- FIFO_Full=1 blocks all pushes that cycle. No push is ever issued while Full is high, so an overrun can only originate outside this block.
- Flush FSM:
  - IDLE: FLUSH_REQ=1 moves to FLUSH and loads counter=FLUSH_CYCLES-1. No push occurs in that cycle.
  - FLUSH:
    - FIFO_Async_Flush=1 (registered; high for exactly FLUSH_CYCLES cycles starting the cycle after FLUSH_REQ is sampled).
    - Counter decrements each cycle; at 0 the FSM moves to SETTLE.
  - SETTLE: one cycle with Async_Flush=0 and pushes still blocked, then → IDLE with FLUSH_DONE=1 (registered) for the first IDLE cycle.
  - FLUSH_BUSY = (state != IDLE).
  - FLUSH_REQ is ignored in FLUSH and SETTLE; it must be re-asserted to start a new flush.
  - FLUSH_REQ high in the FLUSH_DONE cycle starts a new flush immediately.
- Overrun counting:
  - OVERRUN_CNT increments by 1 on each CLK edge where FIFO_Overrun_Error=1.
  - Saturates at 2^CNT_WIDTH-1.
  - Cleared only by RESET; it is not cleared by a flush.

Test Plan:
- Reset, then REQ0_VALID=1 alone with DIN=18'h00A5 → REQ0_READY=1, FIFO_PUSH=1, FIFO_DIN=18'h00A5 in the same cycle; GRANT_ID=1 next cycle.
- Both VALID for 6 cycles with Full=0 → grants go 0,1,0,1,0,1, and FIFO_DIN alternates between REQ0_DIN and REQ1_DIN.
- Both VALID and FIFO_Full=1 for 3 cycles → FIFO_PUSH=0 and both READY=0 throughout; PRI unchanged; after Full drops, the requester at PRI is granted first.
- FLUSH_REQ pulsed with FLUSH_CYCLES=4 and both VALID → Async_Flush high for cycles 1–4, SETTLE at cycle 5, FLUSH_DONE=1 at cycle 6; no FIFO_PUSH in cycles 0–5; pushes resume at cycle 6.
- RESET asserted in the 2nd FLUSH cycle → the next cycle shows Async_Flush=0, FLUSH_BUSY=0, no FLUSH_DONE, GRANT_ID=0.
- CNT_WIDTH=2, FIFO_Overrun_Error held high for 5 cycles → OVERRUN_CNT goes 1,2,3,3,3; the count survives a subsequent flush.

Source files
------------

// File: rtl/sfifo_push_arbiter.sv
// Round-robin push arbiter and flush sequencer for one SFIFO_18K_BLK.
// Tracks FIFO overruns in a saturating status counter.
module sfifo_push_arbiter #(
  parameter int DATA_WIDTH   = 18,
  parameter int FLUSH_CYCLES = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] REQ0_DIN,
  input  logic                  REQ0_VALID,
  output logic                  REQ0_READY,
  input  logic [DATA_WIDTH-1:0] REQ1_DIN,
  input  logic                  REQ1_VALID,
  output logic                  REQ1_READY,
  output logic [DATA_WIDTH-1:0] FIFO_DIN,
  output logic                  FIFO_PUSH,
  output logic                  FIFO_Async_Flush,
  input  logic                  FIFO_Full,
  input  logic                  FIFO_Overrun_Error,
  input  logic                  FLUSH_REQ,
  output logic                  FLUSH_BUSY,
  output logic                  FLUSH_DONE,
  output logic                  GRANT_ID,
  output logic [CNT_WIDTH-1:0]  OVERRUN_CNT
);

  localparam int FCW =
    (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_nstate;
  logic [FCW-1:0]       r_cnt;
  logic [FCW-1:0]       w_ncnt;
  logic                 r_pri;
  logic                 r_done;
  logic                 r_aflush;
  logic [CNT_WIDTH-1:0] r_ovr;

  logic w_push_ok;
  logic w_gnt;
  logic w_push;

  // Contention goes to r_pri; otherwise whichever side is valid.
  assign w_gnt     = (REQ0_VALID & REQ1_VALID) ? r_pri : REQ1_VALID;
  assign w_push_ok = (r_state == IDLE) & ~FLUSH_REQ &
                     ~FIFO_Full & ~RESET;

  assign REQ0_READY = w_push_ok & ~w_gnt;
  assign REQ1_READY = w_push_ok & w_gnt;
  assign w_push     = (REQ0_VALID & REQ0_READY) |
                      (REQ1_VALID & REQ1_READY);

  assign FIFO_PUSH        = w_push;
  assign FIFO_DIN         = (w_push & w_gnt) ? REQ1_DIN : REQ0_DIN;
  assign FIFO_Async_Flush = r_aflush;
  assign FLUSH_BUSY       = (r_state != IDLE);
  assign FLUSH_DONE       = r_done;
  assign GRANT_ID         = r_pri;
  assign OVERRUN_CNT      = r_ovr;

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (FLUSH_REQ) begin
          w_nstate = FLUSH;
          w_ncnt   = FCW'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (r_cnt == '0) w_nstate = SETTLE;
        else             w_ncnt   = r_cnt - 1'b1;
      end
      SETTLE: w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_pri    <= 1'b0;
      r_done   <= 1'b0;
      r_aflush <= 1'b0;
      r_ovr    <= '0;
    end else begin
      r_state  <= w_nstate;
      r_cnt    <= w_ncnt;
      r_done   <= (r_state == SETTLE);
      r_aflush <= (w_nstate == FLUSH);
      if (w_push) r_pri <= ~w_gnt;
      if (FIFO_Overrun_Error && (r_ovr != '1))
        r_ovr <= r_ovr + 1'b1;
    end
  end

endmodule
